rr_dispatch_arbiter: RTL and testbench

//  Shares one single-slot processing unit (valid/ready in, valid/ready out, 8-bit data) among NUM_REQ requesters.

---
 rtl/rr_dispatch_pkg.sv | 24 ++
 rtl/rr_dispatch_arbiter_rr_pick.sv | 48 ++++
 rtl/rr_dispatch_arbiter.sv | 158 +++++++++++++++
 tb/tb_rr_dispatch_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_dispatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rr_dispatch_pkg
//  Brief    : Shared types, defaults and helpers for rr_dispatch_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package rr_dispatch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        RETURN = 2'd3
    } state_t;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 8;

    function automatic int next_idx(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_dispatch_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Brief    : Combinational round-robin picker; first valid at or after rr_ptr.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import rr_dispatch_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       any_valid
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int SW = IW + 1;

    logic [SW-1:0] sum;
    logic [IW-1:0] idx;

    // Scan from the farthest offset down so the nearest valid one wins last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            sum = {1'b0, rr_ptr} + SW'(off);
            if (sum >= SW'(NUM_REQ)) begin
                sum = sum - SW'(NUM_REQ);
            end
            idx = sum[IW-1:0];
            if (req_valid[idx]) begin
                any_valid  = 1'b1;
                grant_idx  = idx;
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_dispatch_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_dispatch_arbiter
//  Brief    : Round-robin dispatcher sharing one single-slot unit among
//             NUM_REQ requesters. Optional WAIT watchdog: RR_DISPATCH_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_dispatch_arbiter
    import rr_dispatch_pkg::*;
#(
    parameter int NUM_REQ     = NUM_REQ_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          rsp_valid,
    input  logic [NUM_REQ-1:0]          rsp_ready,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        unit_in_valid,
    input  logic                        unit_in_ready,
    output logic [DATA_W-1:0]           unit_in_data,
    input  logic                        unit_out_valid,
    output logic                        unit_out_ready,
    input  logic [DATA_W-1:0]           unit_out_data,
    output logic [$clog2(NUM_REQ)-1:0]  owner_id,
    output logic                        busy,
    output logic                        timeout_err
);

    localparam int IW = $clog2(NUM_REQ);

    state_t              state;
    state_t              state_nxt;
    logic [IW-1:0]       rr_ptr;
    logic [NUM_REQ-1:0]  pick_grant;
    logic [IW-1:0]       pick_idx;
    logic                pick_any;
    logic [DATA_W-1:0]   pick_data;

    rr_pick #(
        .NUM_REQ   (NUM_REQ)
    ) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any_valid (pick_any)
    );

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IW'(i)) begin
                pick_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        req_ready      = '0;
        unit_out_ready = 1'b0;
        rsp_valid      = '0;
        busy           = (state != IDLE);
        case (state)
            IDLE: begin
                if (pick_any) begin
                    req_ready = pick_grant;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (unit_in_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                unit_out_ready = 1'b1;
                if (unit_out_valid) begin
                    state_nxt = RETURN;
                end
            end
            RETURN: begin
                rsp_valid[owner_id] = 1'b1;
                if (rsp_ready[owner_id]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr        <= '0;
            owner_id      <= '0;
            unit_in_valid <= 1'b0;
            unit_in_data  <= '0;
            rsp_data      <= '0;
        end else begin
            unit_in_valid <= (state_nxt == ISSUE);
            if (state == IDLE && pick_any) begin
                unit_in_data <= pick_data;
                owner_id     <= pick_idx;
            end
            if (state == WAIT && unit_out_valid) begin
                rsp_data <= unit_out_data;
            end
            if (state == RETURN && rsp_ready[owner_id]) begin
                rr_ptr <= IW'(next_idx(int'(owner_id), NUM_REQ));
            end
        end
    end

`ifdef RR_DISPATCH_TIMEOUT_EN
    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYC);

    logic [15:0] wait_cnt;
    logic        to_flag;

    // Counter restarts on every WAIT entry; the flag is sticky until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            to_flag  <= 1'b0;
        end else if (state != WAIT) begin
            wait_cnt <= '0;
        end else begin
            if (wait_cnt != 16'hFFFF) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
            if (wait_cnt + 16'd1 >= LIMIT) begin
                to_flag <= 1'b1;
            end
        end
    end

    assign timeout_err = to_flag;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC == 0);
    assign timeout_err    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_dispatch_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_dispatch_arbiter
//  Brief    : Vector table plus scoreboard bench for rr_dispatch_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rr_dispatch_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int BOUND = 50;
`ifdef RR_DISPATCH_TIMEOUT_EN
    localparam logic TO_EXP = 1'b1;
`else
    localparam logic TO_EXP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready = '0;
    logic [W-1:0]   rsp_data;
    logic           unit_in_valid;
    logic           unit_in_ready = 1'b0;
    logic [W-1:0]   unit_in_data;
    logic           unit_out_valid = 1'b0;
    logic           unit_out_ready;
    logic [W-1:0]   unit_out_data = '0;
    logic [1:0]     owner_id;
    logic           busy;
    logic           timeout_err;

    rr_dispatch_arbiter #(
        .NUM_REQ        (N),
        .DATA_W         (W),
        .TIMEOUT_CYC    (10)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_data       (req_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .unit_in_valid  (unit_in_valid),
        .unit_in_ready  (unit_in_ready),
        .unit_in_data   (unit_in_data),
        .unit_out_valid (unit_out_valid),
        .unit_out_ready (unit_out_ready),
        .unit_out_data  (unit_out_data),
        .owner_id       (owner_id),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   mask;
        logic [N*W-1:0] data;
        logic [W-1:0]   xr;
        int             in_stall;
        int             out_delay;
        int             rsp_stall;
        logic [N-1:0]   late;
        int             exp_owner;
        logic           exp_to;
    } vec_t;

    typedef struct {
        int           owner;
        logic [W-1:0] data;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[16];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic [N-1:0] m, input logic [N*W-1:0] d,
                                input logic [W-1:0] xr, input int is, input int od,
                                input int rs, input logic [N-1:0] late, input int own,
                                input logic to);
        vec_t v;
        v.mask = m; v.data = d; v.xr = xr; v.in_stall = is; v.out_delay = od;
        v.rsp_stall = rs; v.late = late; v.exp_owner = own; v.exp_to = to;
        return v;
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] one;
        one = 1;
        return one << i;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bail(input string name);
        errors++;
        $display("FAIL %s: wait bound expired (CHECKS %0d ERRORS %0d)", name, checks, errors);
        $fatal(1, "bench stopped");
    endtask

    task automatic do_txn(input vec_t v);
        exp_t         e;
        exp_t         got;
        int           n;
        logic [W-1:0] payload;
        logic [W-1:0] received;
        payload   = v.data[v.exp_owner*W +: W];
        req_data  = v.data;
        req_valid = v.mask;
        e.owner   = v.exp_owner;
        e.data    = payload ^ v.xr;
        sb.push_back(e);
        n = 0;
        #1;
        while (req_ready == '0) begin
            @(negedge clk); #1; n++;
            if (n > BOUND) bail("req_ready wait");
        end
        check("grant", 32'(req_ready), 32'(oh(v.exp_owner)));
        @(negedge clk);
        for (int i = 0; i < v.in_stall; i++) begin
            #1;
            check("issue_hold_valid", 32'(unit_in_valid), 32'd1);
            check("issue_hold_data", 32'(unit_in_data), 32'(payload));
            check("issue_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        unit_in_ready = 1'b1;
        #1; n = 0;
        while (!unit_in_valid) begin
            @(negedge clk); #1; n++;
            if (n > BOUND) bail("unit_in_valid wait");
        end
        check("unit_in_data", 32'(unit_in_data), 32'(payload));
        received = unit_in_data;
        @(negedge clk);
        unit_in_ready = 1'b0;
        repeat (v.out_delay) @(negedge clk);
        unit_out_valid = 1'b1;
        unit_out_data  = received ^ v.xr;
        #1; n = 0;
        while (!unit_out_ready) begin
            @(negedge clk); #1; n++;
            if (n > BOUND) bail("unit_out_ready wait");
        end
        @(negedge clk);
        unit_out_valid = 1'b0;
        unit_out_data  = '0;
        req_valid      = v.late;
        #1; n = 0;
        while (rsp_valid == '0) begin
            @(negedge clk); #1; n++;
            if (n > BOUND) bail("rsp_valid wait");
        end
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: response with empty queue");
            return;
        end
        got = sb.pop_front();
        check("rsp_valid", 32'(rsp_valid), 32'(oh(got.owner)));
        check("rsp_data", 32'(rsp_data), 32'(got.data));
        check("owner_id", 32'(owner_id), 32'(got.owner));
        check("timeout_err", 32'(timeout_err), 32'(v.exp_to));
        for (int i = 0; i < v.rsp_stall; i++) begin
            rsp_ready = ~oh(got.owner);
            @(negedge clk); #1;
            check("rsp_hold_valid", 32'(rsp_valid), 32'(oh(got.owner)));
            check("rsp_hold_data", 32'(rsp_data), 32'(got.data));
            check("return_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = oh(got.owner);
        @(negedge clk);
        rsp_ready = '0;
        #1;
        check("busy_after_rsp", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_unit_in_valid"}, 32'(unit_in_valid), 32'd0);
        check({tag, "_unit_out_ready"}, 32'(unit_out_ready), 32'd0);
        check({tag, "_owner_id"}, 32'(owner_id), 32'd0);
        check({tag, "_unit_in_data"}, 32'(unit_in_data), 32'd0);
        check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    endtask

    initial begin
        // mask, data, xr, in_stall, out_delay, rsp_stall, late, owner, timeout
        vecs[0]  = mk(4'b0010, 32'h0000A500, 8'h00, 0, 0, 0, 4'b0000, 1, 1'b0);
        vecs[1]  = mk(4'b0101, 32'h44332211, 8'h3C, 0, 1, 0, 4'b0000, 0, 1'b0);
        vecs[2]  = mk(4'b1000, 32'h44332211, 8'h3C, 1, 0, 1, 4'b0000, 3, 1'b0);
        vecs[3]  = mk(4'b1111, 32'h13121110, 8'h3C, 0, 0, 0, 4'b0000, 0, 1'b0);
        vecs[4]  = mk(4'b1111, 32'h13121110, 8'h3C, 5, 0, 3, 4'b0000, 1, 1'b0);
        vecs[5]  = mk(4'b1111, 32'h13121110, 8'h3C, 0, 2, 0, 4'b0000, 2, 1'b0);
        vecs[6]  = mk(4'b1111, 32'h13121110, 8'h3C, 0, 0, 0, 4'b0000, 3, 1'b0);
        vecs[7]  = mk(4'b1111, 32'h13121110, 8'h3C, 2, 3, 1, 4'b0000, 0, 1'b0);
        vecs[8]  = mk(4'b1111, 32'h13121110, 8'h3C, 0, 0, 0, 4'b0000, 1, 1'b0);
        vecs[9]  = mk(4'b1111, 32'h13121110, 8'h3C, 0, 0, 0, 4'b0000, 2, 1'b0);
        vecs[10] = mk(4'b1111, 32'h13121110, 8'h3C, 0, 0, 0, 4'b0000, 3, 1'b0);
        vecs[11] = mk(4'b0100, 32'h44332211, 8'hC3, 0, 0, 2, 4'b1000, 2, 1'b0);
        vecs[12] = mk(4'b1011, 32'h44332211, 8'hC3, 0, 0, 0, 4'b0000, 3, 1'b0);
        vecs[13] = mk(4'b0001, 32'h000000E7, 8'h5A, 0, 12, 0, 4'b0000, 0, TO_EXP);
        vecs[14] = mk(4'b0001, 32'h0000007E, 8'h5A, 0, 0, 0, 4'b0000, 0, TO_EXP);
        vecs[15] = mk(4'b0001, 32'h00000081, 8'h00, 0, 0, 0, 4'b0000, 0, TO_EXP);

        repeat (2) @(negedge clk);
        #1;
        check_reset_state("por");
        check("por_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_txn(vecs[0]);

        // Abandon a transaction for requester 3 mid-WAIT with an async reset.
        req_valid = 4'b1000;
        req_data  = 32'h44332211;
        @(negedge clk);
        req_valid     = '0;
        unit_in_ready = 1'b1;
        #1;
        check("abort_issue_valid", 32'(unit_in_valid), 32'd1);
        check("abort_owner", 32'(owner_id), 32'd3);
        @(negedge clk);
        unit_in_ready = 1'b0;
        #1;
        check("abort_in_wait", 32'(unit_out_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_state("midwait");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 1; i < 16; i++) begin
            do_txn(vecs[i]);
        end

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
